// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and helpers for the FIFO-buffered UART transmitter.
package uart_tx_fifo_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Integer divide: any remainder is absorbed as a small baud-rate error.
  function automatic int baud_clocks(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host-side bundle of the UART transmitter: enqueue request/data in, line and FIFO status out.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic                 send;
  logic [DATA_BITS-1:0] din;
  logic                 tx_out;
  logic                 busy;
  logic                 full;
  logic                 overflow;
  logic [LVL_W-1:0]     level;

  modport master (output send, din, input tx_out, busy, full, overflow, level);
  modport slave  (input send, din, output tx_out, busy, full, overflow, level);
endinterface

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO, combinational read of the head entry; push when full / pop when empty ignored.
// level is the authoritative occupancy; pointers wrap modulo DEPTH (power of two).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             wr_en;
  logic             rd_en;

  assign wr_en   = push & ~full;
  assign rd_en   = pop & ~empty;
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter; push edge N -> pop N+1 -> start bit on tx_out at N+2, frames back-to-back.
// No backpressure: a push while full is dropped and flagged by a one-cycle overflow pulse.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 19_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_fifo_if.slave bus
);
  localparam int      BAUD_CLOCKS = baud_clocks(CLK_FREQ, BAUD_RATE);
  localparam int      CNT_W       = $clog2(BAUD_CLOCKS);
  localparam int      LVL_W       = $clog2(FIFO_DEPTH) + 1;
  localparam parity_e PAR_MODE    = parity_e'(PARITY);

  tx_state_e            state_q;
  tx_state_e            state_d;
  logic                 send_q;
  logic                 push;
  logic                 pop;
  logic                 overflow_q;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [LVL_W-1:0]     fifo_level;
  logic [DATA_BITS-1:0] fifo_dat;
  logic [CNT_W-1:0]     baud_cnt;
  logic [3:0]           bit_cnt;
  logic                 baud_done;
  logic                 data_last;
  logic                 stop_last;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic                 tx_d;
  logic                 tx_q;

  assign push      = bus.send & ~send_q;
  assign baud_done = (baud_cnt == CNT_W'(BAUD_CLOCKS - 1));
  assign data_last = (bit_cnt == 4'(DATA_BITS - 1));
  assign stop_last = (bit_cnt == 4'(STOP_BITS - 1));

  // full is sampled before any same-cycle pop, so a push while full is always dropped.
  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (bus.din),
    .pop      (pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      send_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      send_q     <= bus.send;
      overflow_q <= push & fifo_full;
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: if (baud_done) state_d = DATA;
      DATA: begin
        if (baud_done && data_last) begin
          if (PAR_MODE != PAR_NONE) state_d = uart_tx_fifo_pkg::PARITY;
          else                      state_d = STOP;
        end
      end
      uart_tx_fifo_pkg::PARITY: if (baud_done) state_d = STOP;
      STOP: begin
        if (baud_done && stop_last) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters restart on every state entry; bit_cnt counts data bits in DATA and stop bits in STOP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else if (state_d != state_q) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else if (state_q != IDLE) begin
      if (baud_done) begin
        baud_cnt <= '0;
        bit_cnt  <= bit_cnt + 4'd1;
      end else begin
        baud_cnt <= baud_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      par_q   <= 1'b0;
    end else if (pop) begin
      shift_q <= fifo_dat;
      par_q   <= 1'b0;
    end else if (state_q == DATA && baud_done) begin
      shift_q <= shift_q >> 1;
      par_q   <= par_q ^ shift_q[0];
    end
  end

  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      START:                    tx_d = 1'b0;
      DATA:                     tx_d = shift_q[0];
      uart_tx_fifo_pkg::PARITY: tx_d = (PAR_MODE == PAR_ODD) ? ~par_q : par_q;
      default:                  tx_d = 1'b1;
    endcase
  end

  // Registered line driver: tx_out trails the state by one cycle, keeping every bit BAUD_CLOCKS wide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tx_q <= 1'b1;
    else      tx_q <= tx_d;
  end

  assign bus.tx_out   = tx_q;
  assign bus.busy     = (state_q != IDLE) || (fifo_level != '0);
  assign bus.full     = fifo_full;
  assign bus.overflow = overflow_q;
  assign bus.level    = fifo_level;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (no parity/1 stop, odd/2 stop, even/1 stop) at 16 clocks per bit.
module tb_uart_tx_fifo;
  localparam int BC      = 16;
  localparam int FRAME_A = 10 * BC;
  localparam int FRAME_O = 12 * BC;
  localparam int FRAME_E = 11 * BC;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_a ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_o ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_e ();

  uart_tx_fifo #(.CLK_FREQ(100_000_000), .BAUD_RATE(6_250_000), .DATA_BITS(8),
                 .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut_a (.clk(clk), .rst(rst), .bus(if_a));
  uart_tx_fifo #(.CLK_FREQ(100_000_000), .BAUD_RATE(6_250_000), .DATA_BITS(8),
                 .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4))
    dut_o (.clk(clk), .rst(rst), .bus(if_o));
  uart_tx_fifo #(.CLK_FREQ(100_000_000), .BAUD_RATE(6_250_000), .DATA_BITS(8),
                 .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut_e (.clk(clk), .rst(rst), .bus(if_e));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line samples, one per bit period; unused trailing positions are idle-high.
  function automatic logic [11:0] model_frame(input logic [7:0] d, input int par);
    logic [11:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
    if (par != 0) f[9] = (^d) ^ (par == 2);
    return f;
  endfunction

  task automatic push_a(input logic [7:0] b);
    @(negedge clk); if_a.din = b; if_a.send = 1'b1;
    @(negedge clk); if_a.send = 1'b0;
  endtask

  task automatic push_oe(input logic [7:0] b);
    @(negedge clk); if_o.din = b; if_e.din = b; if_o.send = 1'b1; if_e.send = 1'b1;
    @(negedge clk); if_o.send = 1'b0; if_e.send = 1'b0;
  endtask

  task automatic wait_idle_a(input int t0, output int dur);
    int n = 0;
    while (if_a.busy === 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    dur = cyc - t0;
  endtask

  // Receiver model for dut_a: samples mid-bit and checks against the scoreboard.
  always begin : rx_model
    logic [7:0] rx;
    logic [7:0] exp_b;
    @(negedge if_a.tx_out);
    if (mon_en && rst) begin
      repeat (BC/2) @(posedge clk);
      #1 chk("rx_start", 32'(if_a.tx_out), 32'd0);
      for (int i = 0; i < 8; i++) begin
        repeat (BC) @(posedge clk);
        #1 rx[i] = if_a.tx_out;
      end
      repeat (BC) @(posedge clk);
      #1 chk("rx_stop", 32'(if_a.tx_out), 32'd1);
      chk("rx_expected_avail", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        exp_b = exp_q.pop_front();
        chk("rx_data", 32'(rx), 32'(exp_b));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int t0, dur, peak, lows, bhi, n_o, n_e;
    logic [11:0] fr_o, fr_e;
    if_a.send = 1'b0; if_a.din = '0;
    if_o.send = 1'b0; if_o.din = '0;
    if_e.send = 1'b0; if_e.din = '0;
    #23 rst = 1'b1;
    repeat (5) @(negedge clk);

    // Reset pulse while idle
    #2 rst = 1'b0;
    #80 rst = 1'b1;
    @(negedge clk);
    chk("rst_tx", 32'(if_a.tx_out), 32'd1);
    chk("rst_busy", 32'(if_a.busy), 32'd0);
    chk("rst_level", 32'(if_a.level), 32'd0);
    chk("rst_full", 32'(if_a.full), 32'd0);
    chk("rst_overflow", 32'(if_a.overflow), 32'd0);
    chk("rst_tx_odd", 32'(if_o.tx_out), 32'd1);
    chk("rst_tx_even", 32'(if_e.tx_out), 32'd1);
    mon_en = 1'b1;

    // Single byte: latency and frame length
    exp_q.push_back(8'hA5);
    push_a(8'hA5);
    t0 = cyc;
    chk("t2_level_n", 32'(if_a.level), 32'd1);
    chk("t2_busy_n", 32'(if_a.busy), 32'd1);
    chk("t2_tx_n", 32'(if_a.tx_out), 32'd1);
    @(negedge clk);
    chk("t2_tx_n1", 32'(if_a.tx_out), 32'd1);
    chk("t2_level_n1", 32'(if_a.level), 32'd0);
    @(negedge clk);
    chk("t2_tx_fall_n2", 32'(if_a.tx_out), 32'd0);
    wait_idle_a(t0, dur);
    // one idle cycle before the pop, then the whole frame
    chk("t2_busy_len", 32'(dur), 32'(FRAME_A + 1));

    // Fill the FIFO behind a frame in flight, then overflow
    exp_q.push_back(8'h10);
    push_a(8'h10);
    t0 = cyc;
    exp_q.push_back(8'h11); push_a(8'h11);
    exp_q.push_back(8'h22); push_a(8'h22);
    exp_q.push_back(8'h33); push_a(8'h33);
    exp_q.push_back(8'h44); push_a(8'h44);
    chk("t3_full", 32'(if_a.full), 32'd1);
    chk("t3_level", 32'(if_a.level), 32'd4);
    chk("t3_no_ovf", 32'(if_a.overflow), 32'd0);
    push_a(8'h55);
    chk("t3_ovf_pulse", 32'(if_a.overflow), 32'd1);
    chk("t3_level_ovf", 32'(if_a.level), 32'd4);
    @(negedge clk);
    chk("t3_ovf_clear", 32'(if_a.overflow), 32'd0);
    wait_idle_a(t0, dur);
    chk("t3_gapless_len", 32'(dur), 32'(5 * FRAME_A + 1));
    repeat (4) @(negedge clk);
    chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // Odd parity / 2 stop and even parity / 1 stop in parallel, byte 0x03
    push_oe(8'h03);
    fr_o = '0; fr_e = '0; n_o = 0; n_e = 0;
    for (int k = 0; k <= 12 * BC + 4; k++) begin
      if (k == 2) chk("t4_odd_tx_fall", 32'(if_o.tx_out), 32'd0);
      if (k >= 2 && ((k - 2) % BC) == BC/2 && ((k - 2) / BC) < 12) begin
        fr_o[(k-2)/BC] = if_o.tx_out;
        fr_e[(k-2)/BC] = if_e.tx_out;
      end
      if (if_o.busy === 1'b1) n_o++;
      if (if_e.busy === 1'b1) n_e++;
      @(negedge clk);
    end
    chk("t4_odd_parity_bit", 32'(fr_o[9]), 32'd1);
    chk("t4_even_parity_bit", 32'(fr_e[9]), 32'd0);
    chk("t4_odd_frame", 32'(fr_o), 32'(model_frame(8'h03, 2)));
    chk("t4_even_frame", 32'(fr_e), 32'(model_frame(8'h03, 1)));
    chk("t4_odd_busy_len", 32'(n_o), 32'(FRAME_O + 1));
    chk("t4_even_busy_len", 32'(n_e), 32'(FRAME_E + 1));

    // send held high: a single push
    exp_q.push_back(8'h7E);
    @(negedge clk); if_a.din = 8'h7E; if_a.send = 1'b1;
    @(negedge clk);
    t0 = cyc; peak = 0;
    for (int i = 0; i < 20; i++) begin
      if (int'(if_a.level) > peak) peak = int'(if_a.level);
      @(negedge clk);
    end
    if_a.send = 1'b0;
    chk("t5_level_peak", 32'(peak), 32'd1);
    wait_idle_a(t0, dur);
    chk("t5_one_frame_len", 32'(dur), 32'(FRAME_A + 1));
    repeat (4) @(negedge clk);
    chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame with two bytes queued
    mon_en = 1'b0;
    push_a(8'hA5);
    t0 = cyc;
    push_a(8'h5A);
    push_a(8'h3C);
    while (cyc < t0 + 2 + 4 * BC) @(negedge clk);
    chk("t6_pre_busy", 32'(if_a.busy), 32'd1);
    chk("t6_pre_level", 32'(if_a.level), 32'd2);
    chk("t6_pre_tx_bit3", 32'(if_a.tx_out), 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("t6_async_tx", 32'(if_a.tx_out), 32'd1);
    chk("t6_async_busy", 32'(if_a.busy), 32'd0);
    chk("t6_async_level", 32'(if_a.level), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_rel_tx", 32'(if_a.tx_out), 32'd1);
    chk("t6_rel_busy", 32'(if_a.busy), 32'd0);
    chk("t6_rel_level", 32'(if_a.level), 32'd0);
    lows = 0; bhi = 0;
    for (int i = 0; i < 4 * BC; i++) begin
      if (if_a.tx_out !== 1'b1) lows++;
      if (if_a.busy !== 1'b0) bhi++;
      @(negedge clk);
    end
    chk("t6_line_quiet", 32'(lows), 32'd0);
    chk("t6_busy_quiet", 32'(bhi), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
